max7219_frame_serializer: RTL and testbench
===========================================

MAX7219_FRAME_SERIALIZER -- requirements
Module: max7219_frame_serializer

Interface
REQ-001 The block SHALL have parameter DISP_ROWS, default 1, number of 8x8 display rows in the chain.
REQ-002 The block SHALL have parameter DISP_COLUMNS, default 1, number of 8x8 display columns in the chain.
REQ-003 The block SHALL have parameter CLK_DIV, default 4, i_Clk cycles per serial-clock half period; values below 1 are illegal.
REQ-004 The block SHALL have port i_Clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port i_Rst, input, 1, reset; synchronous, active-high.
REQ-006 The block SHALL have port i_MAX7219_DataStream, input, [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0], eight streams of per-device 16-bit command words from the pattern generator.
REQ-007 The block SHALL have port i_Start, input, 1, frame transmit request.
REQ-008 The block SHALL have port o_Busy, output, 1, frame in progress.
REQ-009 The block SHALL have port o_Done, output, 1, one-cycle frame-complete pulse.
REQ-010 The block SHALL have port o_MAX7219_DIN, output, 1, serial data to the first device.
REQ-011 The block SHALL have port o_MAX7219_CLK, output, 1, serial clock.
REQ-012 The block SHALL have port o_MAX7219_LOAD, output, 1, load/chip-select, active-low during shifting.

Function
REQ-013 Definitions: N = DISP_ROWS*DISP_COLUMNS; B = 16*N bits per stream; P = 2*CLK_DIV cycles per bit.
REQ-014 States SHALL be IDLE, SHIFT, LATCH, DONE.
REQ-015 IDLE: i_Start=1 at an edge SHALL be accepted (edge T0), snapshot the whole of i_MAX7219_DataStream, and move to SHIFT with stream index 0 and bit index 0.
REQ-016 Snapshot SHALL isolate transmission from input changes during the frame.
REQ-017 i_Start SHALL be ignored outside IDLE, including the DONE cycle.
REQ-018 SHIFT: o_MAX7219_LOAD=0; each bit SHALL last P cycles: CLK_DIV cycles with CLK=0 and DIN valid, then CLK_DIV cycles with CLK=1 and DIN stable.
REQ-019 Within stream s, words SHALL be sent in descending device index d = r*DISP_COLUMNS + c (d = N-1 first), each word MSB (bit 15) first.
REQ-020 After the high phase of bit B-1, the block SHALL enter LATCH: CLK=0, LOAD=1, DIN=0 for P cycles.
REQ-021 LATCH end: stream index 7 -> DONE; otherwise the next stream in SHIFT with LOAD=0, stream index +1.
REQ-022 Streams SHALL be sent in index order 0..7.
REQ-023 DONE: o_Done=1 for exactly one cycle, then IDLE.
REQ-024 o_Done SHALL occur in cycle T0 + 8*(B+1)*P + 1.
REQ-025 o_Busy SHALL be 1 from T0+1 through the DONE cycle inclusive, otherwise 0.
REQ-026 If i_Start is held high continuously, the next frame SHALL be accepted on the first IDLE edge after DONE.
REQ-027 Bit and cycle counters SHALL be sized for B*P without overflow for any legal parameters.
REQ-028 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-029 While i_Rst=1 at an edge: state IDLE, o_Busy=0, o_Done=0, DIN=0, CLK=0, LOAD=1, counters 0.
REQ-030 Reset SHALL dominate i_Start in the same cycle.
REQ-031 Reset mid-frame SHALL abort the frame with no o_Done pulse; the next frame restarts from stream 0.

Verification
REQ-032 N=1, CLK_DIV=2, streams 0..7 = 0x0101..0x0801, pulse i_Start -> 8 LOAD-low windows of 16 CLK rises each; sampled DIN words 0x0101..0x0801 in order; o_Done at T0+8*17*4+1 = T0+545.
REQ-033 DISP_ROWS=1, DISP_COLUMNS=2, stream 0 = {d1=0x0AAA, d0=0x0155} -> within window 0, first 16 bits 0x0AAA, then 0x0155; 32 CLK rises per window.
REQ-034 Change i_MAX7219_DataStream to all 0xFFFF one cycle after T0 -> transmitted words equal the pre-start snapshot.
REQ-035 Pulse i_Start again mid-frame -> ignored; exactly one o_Done; o_Busy never drops mid-frame.
REQ-036 Assert i_Rst during stream 3 -> next edge LOAD=1, CLK=0, o_Busy=0, no o_Done; a new i_Start produces a full correct frame.
REQ-037 Hold i_Start high for 3 frames -> 3 o_Done pulses, each exactly 8*(B+1)*P+2 cycles apart; CLK high/low phases each exactly CLK_DIV cycles throughout.

Source files
------------

// File: rtl/max7219_frame_serializer.sv
// Serializes one display frame to a MAX7219 daisy chain: eight streams of per-device command
// words, each shifted MSB first with LOAD low, then latched with a LOAD-high gap.
module max7219_frame_serializer #(
  parameter int unsigned DISP_ROWS    = 1,
  parameter int unsigned DISP_COLUMNS = 1,
  parameter int unsigned CLK_DIV      = 4
) (
  input  logic                                              i_Clk,
  input  logic                                              i_Rst,
  input  logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] i_MAX7219_DataStream,
  input  logic                                              i_Start,
  output logic                                              o_Busy,
  output logic                                              o_Done,
  output logic                                              o_MAX7219_DIN,
  output logic                                              o_MAX7219_CLK,
  output logic                                              o_MAX7219_LOAD
);

  localparam int unsigned N    = DISP_ROWS * DISP_COLUMNS;
  localparam int unsigned B    = 16 * N;
  localparam int unsigned P    = 2 * CLK_DIV;
  localparam int unsigned PhW  = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned BitW = $clog2(B);

  localparam logic [PhW-1:0]  PhaseLast = PhW'(P - 1);
  localparam logic [PhW-1:0]  PhaseHigh = PhW'(CLK_DIV);
  localparam logic [BitW-1:0] BitLast   = BitW'(B - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StLatch = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [PhW-1:0]  phase_q, phase_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [2:0]      strm_q, strm_d;

  logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] snap_q, snap_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic din_q, din_d;
  logic sclk_q, sclk_d;
  logic load_q, load_d;

  logic [B-1:0]    stream_bits;
  logic [BitW-1:0] bit_sel;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    strm_d  = strm_q;
    snap_d  = snap_q;
    case (state_q)
      StIdle: begin
        if (i_Start) begin
          state_d = StShift;
          snap_d  = i_MAX7219_DataStream;
          phase_d = '0;
          bit_d   = '0;
          strm_d  = '0;
        end
      end
      StShift: begin
        if (phase_q == PhaseLast) begin
          phase_d = '0;
          if (bit_q == BitLast) begin
            bit_d   = '0;
            state_d = StLatch;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StLatch: begin
        if (phase_q == PhaseLast) begin
          phase_d = '0;
          if (strm_q == 3'd7) begin
            state_d = StDone;
          end else begin
            strm_d  = strm_q + 3'd1;
            state_d = StShift;
          end
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        strm_d  = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from next-state values so every pin comes straight from a flop.
  always_comb begin
    stream_bits = snap_d[strm_d];
    // Highest device index occupies the top bits, so counting down from B-1 sends it first.
    bit_sel     = BitLast - bit_d;
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    load_d      = (state_d != StShift);
    sclk_d      = (state_d == StShift) && (phase_d >= PhaseHigh);
    din_d       = (state_d == StShift) ? stream_bits[bit_sel] : 1'b0;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= StIdle;
      phase_q <= '0;
      bit_q   <= '0;
      strm_q  <= '0;
      snap_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      din_q   <= 1'b0;
      sclk_q  <= 1'b0;
      load_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      strm_q  <= strm_d;
      snap_q  <= snap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      din_q   <= din_d;
      sclk_q  <= sclk_d;
      load_q  <= load_d;
    end
  end

  assign o_Busy         = busy_q;
  assign o_Done         = done_q;
  assign o_MAX7219_DIN  = din_q;
  assign o_MAX7219_CLK  = sclk_q;
  assign o_MAX7219_LOAD = load_q;

endmodule

// File: tb/tb_max7219_frame_serializer.sv
// Directed/random bench for the MAX7219 frame serializer: a negedge monitor decodes the serial
// pins into LOAD windows and compares them with words built from the stimulus arrays.
module tb_max7219_frame_serializer;

  localparam int unsigned R  = 1;
  localparam int unsigned C  = 2;
  localparam int unsigned CD = 2;
  localparam int unsigned N  = R * C;
  localparam int unsigned B  = 16 * N;
  localparam int unsigned P  = 2 * CD;
  localparam int unsigned M  = 8 * (B + 1) * P;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [0:7][R-1:0][C-1:0][15:0] data;
  logic busy, done, din, sclk, load;

  max7219_frame_serializer #(
    .DISP_ROWS   (R),
    .DISP_COLUMNS(C),
    .CLK_DIV     (CD)
  ) dut (
    .i_Clk               (clk),
    .i_Rst               (rst),
    .i_MAX7219_DataStream(data),
    .i_Start             (start),
    .o_Busy              (busy),
    .o_Done              (done),
    .o_MAX7219_DIN       (din),
    .o_MAX7219_CLK       (sclk),
    .o_MAX7219_LOAD      (load)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  bit [15:0]    w [8][N];
  logic [B-1:0] win_val[$];
  int           win_bits[$];
  int           done_at[$];
  int           phase_err = 0;
  int           busy_err = 0;
  int           done_err = 0;

  logic         p_clk, p_load, p_busy, p_done;
  int           hi_run, lo_run, nbits;
  logic [B-1:0] acc;

  // Monitor: done_at holds the cycle number (edge index) in which o_Done is sampled high.
  always @(negedge clk) begin
    if (rst) begin
      p_clk = 1'b0; p_load = 1'b1; p_busy = 1'b0; p_done = 1'b0;
      hi_run = 0; lo_run = 0; nbits = 0; acc = '0;
    end else begin
      if (sclk) begin
        if (load) phase_err++;
        if (!p_clk) begin
          if (lo_run != CD) phase_err++;
          acc = {acc[B-2:0], din};
          nbits++;
          hi_run = 0;
        end
        hi_run++;
      end else begin
        if (p_clk && hi_run != CD) phase_err++;
        if (!load) lo_run = p_clk ? 1 : lo_run + 1;
        else lo_run = 0;
      end
      if (load && !p_load) begin
        win_val.push_back(acc);
        win_bits.push_back(nbits);
        acc = '0;
        nbits = 0;
      end
      if (done) begin
        done_at.push_back(cyc + 1);
        if (p_done || !busy) done_err++;
      end
      if (p_busy && !busy && !p_done) busy_err++;
      p_clk = sclk; p_load = load; p_busy = busy; p_done = done;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_data();
    for (int s = 0; s < 8; s++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          data[s][r][c] = w[s][r*C+c];
  endtask

  task automatic randomize_words();
    for (int s = 0; s < 8; s++)
      for (int d = 0; d < N; d++)
        w[s][d] = 16'($urandom);
  endtask

  // Expected serial order: device N-1 first, each word MSB first.
  function automatic logic [B-1:0] exp_win(input int s);
    logic [B-1:0] e = '0;
    for (int d = N - 1; d >= 0; d--) e = (e << 16) | B'(w[s][d]);
    return e;
  endfunction

  task automatic clear_mon();
    win_val.delete();
    win_bits.delete();
    done_at.delete();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame(output int t0);
    start = 1'b1;
    step(1);
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int k = 0;
    while (done_at.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 64'(done_at.size() >= n), 64'd1);
  endtask

  task automatic check_windows(input int nwin, input string tag);
    int lim;
    check({tag, "_count"}, 64'(win_val.size()), 64'(nwin));
    lim = (win_val.size() < nwin) ? win_val.size() : nwin;
    for (int i = 0; i < lim; i++) begin
      check($sformatf("%s_bits%0d", tag, i), 64'(win_bits[i]), 64'(B));
      check($sformatf("%s_word%0d", tag, i), 64'(win_val[i]), 64'(exp_win(i % 8)));
    end
  endtask

  initial begin
    int t0;
    int k;
    data = '0;
    step(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_load", 64'(load), 64'd1);
    check("rst_clk", 64'(sclk), 64'd0);
    check("rst_din", 64'(din), 64'd0);

    // Reset wins over a simultaneous start.
    start = 1'b1;
    step(1);
    check("rst_dom_busy", 64'(busy), 64'd0);
    check("rst_dom_load", 64'(load), 64'd1);
    start = 1'b0;
    rst = 1'b0;
    step(2);
    check("idle_busy", 64'(busy), 64'd0);

    // Frame A: two-device words, input changed after T0, extra start mid-frame.
    randomize_words();
    w[0][1] = 16'h0AAA;
    w[0][0] = 16'h0155;
    for (int s = 1; s < 8; s++) w[s][1] = 16'(((s + 1) << 8) | 1);
    apply_data();
    clear_mon();
    start_frame(t0);
    check("a_busy_t0p1", 64'(busy), 64'd1);
    check("a_load_t0p1", 64'(load), 64'd0);
    check("a_clk_t0p1", 64'(sclk), 64'd0);
    check("a_din_first", 64'(din), 64'(w[0][N-1][15]));
    data = '1;
    step(300);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("a_busy_mid", 64'(busy), 64'd1);
    wait_done(1, M + 50, "a_done_seen");
    if (done_at.size() >= 1) check("a_done_time", 64'(done_at[0]), 64'(t0 + M + 1));
    step(10);
    check("a_done_once", 64'(done_at.size()), 64'd1);
    check("a_busy_after", 64'(busy), 64'd0);
    check("a_load_after", 64'(load), 64'd1);
    check_windows(8, "a_win");

    // Frame B: reset during stream 3 aborts, then a fresh frame.
    randomize_words();
    apply_data();
    clear_mon();
    start_frame(t0);
    step(3 * (B + 1) * P + 40);
    rst = 1'b1;
    step(1);
    check("b_rst_load", 64'(load), 64'd1);
    check("b_rst_clk", 64'(sclk), 64'd0);
    check("b_rst_busy", 64'(busy), 64'd0);
    check("b_rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    check_windows(3, "b_partial");
    step(5);
    check("b_no_done", 64'(done_at.size()), 64'd0);
    randomize_words();
    apply_data();
    clear_mon();
    start_frame(t0);
    wait_done(1, M + 50, "b_done_seen");
    if (done_at.size() >= 1) check("b_done_time", 64'(done_at[0]), 64'(t0 + M + 1));
    step(4);
    check_windows(8, "b_win");

    // Frame C: start held for three back-to-back frames.
    randomize_words();
    apply_data();
    clear_mon();
    start = 1'b1;
    step(1);
    t0 = cyc;
    k = 0;
    while (done_at.size() < 3 && k < 3 * (M + 2) + 50) begin
      step(1);
      k++;
    end
    start = 1'b0;
    step(5);
    check("c_done_count", 64'(done_at.size()), 64'd3);
    if (done_at.size() >= 3) begin
      check("c_done0_time", 64'(done_at[0]), 64'(t0 + M + 1));
      check("c_gap01", 64'(done_at[1] - done_at[0]), 64'(M + 2));
      check("c_gap12", 64'(done_at[2] - done_at[1]), 64'(M + 2));
    end
    check_windows(24, "c_win");

    check("phase_width", 64'(phase_err), 64'd0);
    check("busy_drop", 64'(busy_err), 64'd0);
    check("done_pulse", 64'(done_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
